// File: rtl/ipv4_rx_decode.sv
// IPv4 receive header parser: checks the header, strips options/padding, forwards the payload.
// Optional macro IPV4_CHECKSUM_EN builds the header checksum accumulator (error code 3).
module ipv4_rx_decode #(
    parameter logic [31:0] IP_ADDR = 32'h69696969
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  din,
    output logic [31:0] sa,
    output logic [31:0] da,
    output logic [7:0]  protocol,
    output logic [15:0] payload_len,
    output logic        hdr_valid,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        dout_last,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CODE_W = 3;
    localparam logic [31:0] BCAST_ADDR = 32'hFFFF_FFFF;

    localparam logic [CODE_W-1:0] ERR_VERSION  = CODE_W'(1);
    localparam logic [CODE_W-1:0] ERR_FRAG     = CODE_W'(2);
    localparam logic [CODE_W-1:0] ERR_CSUM     = CODE_W'(3);
    localparam logic [CODE_W-1:0] ERR_DA       = CODE_W'(4);
    localparam logic [CODE_W-1:0] ERR_LEN      = CODE_W'(5);
    localparam logic [CODE_W-1:0] ERR_TRUNC    = CODE_W'(6);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        HEADER,
        PAYLOAD,
        DRAIN
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0]  cnt;
    logic [3:0]        ihl_r;
    logic [15:0]       tot_len_r;
    logic [13:0]       frag_r;
    logic [7:0]        proto_r;
    logic [31:0]       sa_r;
    logic [31:0]       da_r;

    logic [CNT_W-1:0]  hdr_bytes;
    logic [CNT_W-1:0]  hdr_end;
    logic [15:0]       pay_len;
    logic [31:0]       da_fin;
    logic              frag_bad;
    logic              da_bad;
    logic              len_bad;
    logic              csum_bad;

    logic              hdr_valid_n;
    logic              err_n;
    logic [CODE_W-1:0] err_code_n;
    logic [7:0]        dout_n;
    logic              dout_valid_n;
    logic              dout_last_n;
    logic              load_hdr;

    // Header-derived values; DA may complete on the very byte the checks run.
    always_comb begin
        hdr_bytes = CNT_W'({ihl_r, 2'b00});
        hdr_end   = hdr_bytes - CNT_W'(1);
        pay_len   = tot_len_r - hdr_bytes;
        da_fin    = (cnt == CNT_W'(19)) ? {da_r[23:0], din} : da_r;
        frag_bad  = frag_r[13] | (frag_r[12:0] != 13'd0);
        da_bad    = (da_fin != IP_ADDR) && (da_fin != BCAST_ADDR);
        len_bad   = tot_len_r < hdr_bytes;
    end

`ifdef IPV4_CHECKSUM_EN
    logic [7:0]  csum_hi;
    logic [15:0] csum_acc;
    logic [16:0] csum_raw;
    logic [15:0] csum_fin;

    // Ones-complement word sum with end-around carry; a good header folds to 16'hFFFF.
    always_comb begin
        csum_raw = {1'b0, csum_acc} + {1'b0, csum_hi, din};
        csum_fin = csum_raw[15:0] + 16'(csum_raw[16]);
        csum_bad = (csum_fin != 16'hFFFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_hi  <= '0;
            csum_acc <= '0;
        end else if (state == IDLE && valid) begin
            csum_hi  <= din;
            csum_acc <= '0;
        end else if (state == HEADER && valid) begin
            if (cnt[0]) begin
                csum_acc <= csum_fin;
            end else begin
                csum_hi <= din;
            end
        end
    end
`else
    assign csum_bad = 1'b0;
`endif

    // Byte counter and header field capture by byte index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            ihl_r     <= '0;
            tot_len_r <= '0;
            frag_r    <= '0;
            proto_r   <= '0;
            sa_r      <= '0;
            da_r      <= '0;
        end else if (state == IDLE && valid) begin
            cnt   <= CNT_W'(1);
            ihl_r <= din[3:0];
        end else if ((state == HEADER || state == PAYLOAD) && valid) begin
            cnt <= cnt + CNT_W'(1);
            if (state == HEADER) begin
                case (cnt)
                    CNT_W'(2):  tot_len_r[15:8] <= din;
                    CNT_W'(3):  tot_len_r[7:0]  <= din;
                    CNT_W'(6):  frag_r[13:8]    <= din[5:0];
                    CNT_W'(7):  frag_r[7:0]     <= din;
                    CNT_W'(9):  proto_r         <= din;
                    CNT_W'(12), CNT_W'(13), CNT_W'(14), CNT_W'(15):
                                sa_r <= {sa_r[23:0], din};
                    CNT_W'(16), CNT_W'(17), CNT_W'(18), CNT_W'(19):
                                da_r <= {da_r[23:0], din};
                    default: ;
                endcase
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_n      = state;
        hdr_valid_n  = 1'b0;
        err_n        = 1'b0;
        err_code_n   = err_code;
        dout_n       = dout;
        dout_valid_n = 1'b0;
        dout_last_n  = 1'b0;
        load_hdr     = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (!valid) state_n = IDLE;
            end
            IDLE: begin
                if (valid) begin
                    if (din[7:4] != 4'd4 || din[3:0] < 4'd5) begin
                        err_n      = 1'b1;
                        err_code_n = ERR_VERSION;
                        state_n    = DRAIN;
                    end else begin
                        state_n = HEADER;
                    end
                end
            end
            HEADER: begin
                if (!valid) begin
                    err_n      = 1'b1;
                    err_code_n = ERR_TRUNC;
                    state_n    = IDLE;
                end else if (cnt == hdr_end) begin
                    state_n = DRAIN;
                    err_n   = 1'b1;
                    if (frag_bad) begin
                        err_code_n = ERR_FRAG;
                    end else if (csum_bad) begin
                        err_code_n = ERR_CSUM;
                    end else if (da_bad) begin
                        err_code_n = ERR_DA;
                    end else if (len_bad) begin
                        err_code_n = ERR_LEN;
                    end else begin
                        err_n       = 1'b0;
                        hdr_valid_n = 1'b1;
                        load_hdr    = 1'b1;
                        state_n     = (pay_len == 16'd0) ? DRAIN : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!valid) begin
                    err_n      = 1'b1;
                    err_code_n = ERR_TRUNC;
                    state_n    = IDLE;
                end else begin
                    dout_n       = din;
                    dout_valid_n = 1'b1;
                    if (cnt == tot_len_r - CNT_W'(1)) begin
                        dout_last_n = 1'b1;
                        state_n     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!valid) state_n = IDLE;
            end
            default: state_n = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_IDLE;
            sa          <= '0;
            da          <= '0;
            protocol    <= '0;
            payload_len <= '0;
            hdr_valid   <= 1'b0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            dout_last   <= 1'b0;
            err         <= 1'b0;
            err_code    <= '0;
        end else begin
            state      <= state_n;
            hdr_valid  <= hdr_valid_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            dout_last  <= dout_last_n;
            err        <= err_n;
            err_code   <= err_code_n;
            if (load_hdr) begin
                sa          <= sa_r;
                da          <= da_fin;
                protocol    <= proto_r;
                payload_len <= pay_len;
            end
        end
    end

endmodule
